// File: rtl/pkt_req_arbiter.sv
// Round-robin scheduler that shares one packet read/write engine pair between
// NUM_REQ requesters, with completion tracking, timeout abort and statistics.
module pkt_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       rd_done,
  input  logic                       wr_done,
  output logic                       start,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [CNT_W-1:0]           err_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               rd_seen_q, rd_seen_d;
  logic               wr_seen_q, wr_seen_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] pick_vec;
  logic [ID_W-1:0]    sel_id;
  logic               rd_any, wr_any, txn_complete, tmo_hit;

  // Requests strictly above the pointer win; if none, wrap to the lowest set bit.
  // A pointer at the top index shifts the mask out entirely, forcing the wrap.
  always_comb begin
    // NOTE: every signal written here is assigned before any condition, so no latch can be inferred.
    upper_mask = ~((NUM_REQ'(2) << ptr_q) - NUM_REQ'(1));
    pick_vec   = (|(req & upper_mask)) ? (req & upper_mask) : req;
    sel_id     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    ptr_d        = ptr_q;
    rd_seen_d    = rd_seen_q;
    wr_seen_d    = wr_seen_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    rd_any       = rd_seen_q | rd_done;
    wr_any       = wr_seen_q | wr_done;
    txn_complete = rd_any & wr_any;
    tmo_hit      = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    unique case (state_q)
      S_IDLE: begin
        if (enable && (|req)) begin
          grant_d    = NUM_REQ'(1) << sel_id;
          grant_id_d = sel_id;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        // Done pulses seen here belong to no transaction and are dropped.
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        tmo_cnt_d = '0;
        err_d     = 1'b0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        rd_seen_d = rd_any;
        wr_seen_d = wr_any;
        if (txn_complete) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        if (err_q) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
          if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
        ptr_d      = grant_id_q;
        grant_d    = '0;
        grant_id_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      rd_seen_q  <= rd_seen_d;
      wr_seen_q  <= wr_seen_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign start       = (state_q == S_GRANT);
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign ack         = (state_q == S_DONE) ? grant_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = (state_q == S_DONE) & err_q;
  assign pkt_count   = pkt_cnt_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_pkt_req_arbiter.sv
// Self-checking bench for pkt_req_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_pkt_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [NUM_REQ-1:0]   req;
  logic                 rd_done;
  logic                 wr_done;
  logic                 start;
  logic [NUM_REQ-1:0]   grant;
  logic [1:0]           grant_id;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic                 timeout_err;
  logic [CNT_W-1:0]     pkt_count;
  logic [CNT_W-1:0]     err_count;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr;
  int m_pkt;
  int m_err;

  // Done masks: bit k = pulse driven in WAIT cycle k; bit 0 is the GRANT cycle.
  typedef struct {
    logic [3:0]  req;
    logic [15:0] rdm;
    logic [15:0] wrm;
    bit          drop;
    int          exp_id;
    int          exp_w;
    bit          exp_ok;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  pkt_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .rd_done     (rd_done),
    .wr_done     (wr_done),
    .start       (start),
    .grant       (grant),
    .grant_id    (grant_id),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pkt_count   (pkt_count),
    .err_count   (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next requester after the last served one, scanning upward with wrap-around.
  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    int  id;
    bit  found;
    id    = -1;
    found = 1'b0;
    for (int step = 1; step <= NUM_REQ; step++) begin
      if (!found && r[(ptr + step) % NUM_REQ]) begin
        id    = (ptr + step) % NUM_REQ;
        found = 1'b1;
      end
    end
    return id;
  endfunction

  // WAIT cycle at which the transaction ends, and whether it ended by completion.
  task automatic predict(input logic [15:0] rdm, input logic [15:0] wrm, output int w, output bit ok);
    bit rs, ws;
    rs = 1'b0;
    ws = 1'b0;
    w  = TMO;
    ok = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      rs = rs | rdm[k];
      ws = ws | wrm[k];
      if (!ok && rs && ws) begin
        w  = k;
        ok = 1'b1;
      end
    end
  endtask

  // Starts with the DUT in IDLE; ends one cycle into the following IDLE.
  task automatic run_txn(input logic [3:0] r, input logic [15:0] rdm, input logic [15:0] wrm,
                         input bit drop, input bit hold, input int exp_id, input int exp_w,
                         input bit exp_ok);
    logic [3:0] exp_oh;
    exp_oh  = 4'(1 << exp_id);
    req     = r;
    enable  = 1'b1;
    rd_done = 1'b0;
    wr_done = 1'b0;
    tick();
    check("grant_start", start, 1);
    check("grant_vec", grant, exp_oh);
    check("grant_id", grant_id, exp_id);
    check("grant_busy", busy, 1);
    rd_done = rdm[0];
    wr_done = wrm[0];
    if (drop) begin
      req    = '0;
      enable = 1'b0;
    end
    for (int k = 1; k <= exp_w; k++) begin
      tick();
      check("wait_ack", ack, 0);
      check("wait_start", start, 0);
      check("wait_grant", grant, exp_oh);
      rd_done = rdm[k];
      wr_done = wrm[k];
    end
    tick();
    check("done_ack", ack, exp_oh);
    check("done_timeout_err", timeout_err, !exp_ok);
    check("done_grant_id", grant_id, exp_id);
    rd_done = rdm[exp_w + 1];
    wr_done = wrm[exp_w + 1];
    if (!hold) req = '0;
    if (exp_ok) begin
      if (m_pkt < CNT_MAX) m_pkt++;
    end else begin
      if (m_err < CNT_MAX) m_err++;
    end
    m_ptr = exp_id;
    tick();
    rd_done = 1'b0;
    wr_done = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("idle_ack", ack, 0);
    check("pkt_count", pkt_count, m_pkt);
    check("err_count", err_count, m_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0100, 16'h0008, 16'h0020, 1'b0, 2, 5, 1'b1};
    vecs[1] = '{4'b0001, 16'h0004, 16'h0004, 1'b0, 0, 2, 1'b1};
    vecs[2] = '{4'b0010, 16'h0011, 16'h0002, 1'b0, 1, 4, 1'b1};
    vecs[3] = '{4'b1000, 16'h0004, 16'h0000, 1'b0, 3, 8, 1'b0};
    vecs[4] = '{4'b0100, 16'h0002, 16'h0100, 1'b0, 2, 8, 1'b1};
    vecs[5] = '{4'b0001, 16'h0001, 16'h0001, 1'b0, 0, 8, 1'b0};
    vecs[6] = '{4'b1001, 16'h0040, 16'h0002, 1'b1, 3, 6, 1'b1};
    vecs[7] = '{4'b0011, 16'h0008, 16'h0200, 1'b0, 0, 8, 1'b0};
    vecs[8] = '{4'b0011, 16'h0100, 16'h0100, 1'b0, 1, 8, 1'b1};

    reset   = 1'b1;
    enable  = 1'b0;
    req     = '0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    m_ptr   = NUM_REQ - 1;
    m_pkt   = 0;
    m_err   = 0;
    #2;
    check("rst_start", start, 0);
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_err_count", err_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].req, vecs[v].rdm, vecs[v].wrm, vecs[v].drop, 1'b0,
              vecs[v].exp_id, vecs[v].exp_w, vecs[v].exp_ok);
    end

    // enable low blocks new grants even with a pending request
    enable = 1'b0;
    req    = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("disabled_start", start, 0);
      check("disabled_busy", busy, 0);
    end
    run_txn(4'b0001, 16'h0002, 16'h0002, 1'b0, 1'b0, 0, 1, 1'b1);

    // asynchronous reset in the middle of WAIT
    req    = 4'b0100;
    enable = 1'b1;
    tick();
    tick();
    tick();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_grant", grant, 4'b0100);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_start", start, 0);
    check("async_rst_grant", grant, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ack", ack, 0);
    check("async_rst_pkt", pkt_count, 0);
    check("async_rst_err", err_count, 0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = NUM_REQ - 1;
    m_pkt = 0;
    m_err = 0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_ack", ack, 0);

    // fairness with every request held high
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 16'h0008, 16'h0008, 1'b0, (i < 4), i % NUM_REQ, 3, 1'b1);
    end

    // randomized transactions against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  r;
      logic [15:0] rdm;
      logic [15:0] wrm;
      int          id;
      int          w;
      bit          ok;
      r   = 4'($urandom_range(1, 15));
      rdm = '0;
      wrm = '0;
      for (int k = 0; k <= 10; k++) begin
        rdm[k] = ($urandom_range(0, 3) == 0);
        wrm[k] = ($urandom_range(0, 3) == 0);
      end
      id = rr_pick(r, m_ptr);
      predict(rdm, wrm, w, ok);
      run_txn(r, rdm, wrm, ($urandom_range(0, 4) == 0), 1'b0, id, w, ok);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_req_arbiter.md
Name: pkt_req_arbiter

Overview:
- Round-robin scheduler that shares one packet read/write engine pair between NUM_REQ capture requesters.
- Per transaction: grants one requester, issues a single-cycle start to both engines, and waits for both engines to report completion (or a timeout). It then acknowledges the requester and re-arbitrates.
- Sits between the per-port capture front-ends and the shared read/write control engines.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT before the transaction is aborted; must be >= 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: when low, no new grants are issued; an in-flight transaction still completes.
- req, input, NUM_REQ: level request per requester; the requester holds it until ack.
- rd_done, input, 1: one-cycle completion pulse from the read engine.
- wr_done, input, 1: one-cycle completion pulse from the write engine.
- start, output, 1: one-cycle pulse to both engines.
- grant, output, NUM_REQ: one-hot grant vector.
- grant_id, output, clog2(NUM_REQ): index of the granted requester.
- ack, output, NUM_REQ: one-hot, one-cycle completion pulse to the granted requester.
- busy, output, 1: high in any state other than IDLE.
- timeout_err, output, 1: one-cycle pulse when a transaction is aborted.
- pkt_count, output, CNT_W: transactions completed successfully; saturating.
- err_count, output, CNT_W: transactions aborted by timeout; saturating.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All outputs = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Done latches cleared; timeout counter = 0.
- States: IDLE, GRANT, WAIT, DONE.
- IDLE:
  - If enable=1 and any req bit=1, select the first set bit searching upward from pointer+1, with wrap-around.
  - Register grant/grant_id and move to GRANT.
  - Otherwise stay in IDLE.
  - grant=0 while in IDLE.
- GRANT (exactly 1 cycle):
  - start=1.
  - Clear rd/wr done latches and the timeout counter.
  - Next state: WAIT.
  - rd_done/wr_done arriving in this cycle are ignored.
- WAIT:
  - rd_done sets its latch; wr_done sets its latch. Latches are sticky.
  - Completion condition: (latch or pulse this cycle) is true for both engines. Simultaneous pulses, or a pulse arriving in the same cycle as the other latch, satisfy it.
  - If completion holds: go to DONE, outcome = ok.
  - Else if timeout counter = TIMEOUT_CYCLES-1: go to DONE, outcome = err.
  - Else increment the counter.
  - Completion takes priority over timeout when both occur in the same cycle.
- DONE (exactly 1 cycle):
  - ack[grant_id]=1.
  - If ok: pkt_count increments. If err: timeout_err=1 and err_count increments.
  - Counters saturate at all-ones.
  - pointer = grant_id.
  - Next state: IDLE.
- grant/grant_id are held constant from GRANT through DONE and cleared on entering IDLE.
- Latency:
  - req seen in IDLE at cycle 0 -> GRANT/start at cycle 1 -> WAIT from cycle 2.
  - Last done at cycle k -> ack at k+1 -> IDLE at k+2 -> next GRANT at k+3 at the earliest.
- A requester that drops req mid-transaction is still served to completion and still receives ack.
- enable falling mid-transaction has no effect until the state returns to IDLE.
- Done pulses arriving in IDLE or DONE are ignored and not latched.
- Reset asserted mid-transaction aborts immediately to the reset state. No ack is issued and no counter is updated.
- Fairness: with all req held high, grants rotate 0,1,...,NUM_REQ-1,0,...

Test Plan:
1. Single request: req=4'b0100; rd_done at cycle 4, wr_done at cycle 6 -> start only at cycle 1; grant=4'b0100 and grant_id=2 for cycles 1..7; ack=4'b0100 at cycle 7; pkt_count=1; busy low from cycle 8.
2. Round-robin: req=4'b1111 held; engines respond 3 cycles after each start -> grant_id sequence 0,1,2,3,0; exactly one ack per grant.
3. Simultaneous done: rd_done and wr_done in the same WAIT cycle -> DONE next cycle. A done pulse in the GRANT cycle is ignored: with rd_done only in GRANT, completion requires a later rd_done.
4. Timeout: TIMEOUT_CYCLES=8; rd_done arrives but wr_done never does -> DONE after exactly 8 WAIT cycles; timeout_err=1 and ack for one cycle; err_count=1; pkt_count unchanged. Completion in cycle 8 of WAIT -> ok, not err.
5. Enable/drop: enable=0 with req=4'b0001 -> no start. With enable raised and req dropped after grant -> transaction still completes with ack.
6. Reset mid-WAIT: assert reset asynchronously between clock edges -> grant, start, busy and ack are 0 immediately; counters are 0; requester 0 has priority after release.
